// File: rtl/serial_magnitude_compare.sv
// rtl/serial_magnitude_compare.sv - MSB-first serial magnitude comparator with held gt/lt/eq flags
module serial_magnitude_compare #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic gt,
  output logic lt,
  output logic eq
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            decided, gt_i, lt_i;
  logic            load, accept, last;
  logic            gt_f, lt_f;

  assign busy = (state == COMPARE);

  // The first differing bit pair decides; the result then stays frozen.
  assign gt_f = decided ? gt_i : (a_bit & ~b_bit);
  assign lt_f = decided ? lt_i : (~a_bit & b_bit);

  always_comb begin
    state_n = state;
    load    = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = COMPARE;
          load    = 1'b1;
        end
      end
      COMPARE: begin
        accept = bit_valid;
        last   = bit_valid && (cnt == LAST);
        if (last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      decided <= 1'b0;
      gt_i    <= 1'b0;
      lt_i    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        cnt     <= '0;
        decided <= 1'b0;
        gt_i    <= 1'b0;
        lt_i    <= 1'b0;
      end else if (accept) begin
        cnt     <= cnt + CW'(1);
        decided <= decided | (a_bit ^ b_bit);
        gt_i    <= gt_f;
        lt_i    <= lt_f;
      end
      // Result flags move only on the completing edge.
      if (last) begin
        gt <= gt_f;
        lt <= lt_f;
        eq <= ~(gt_f | lt_f);
      end
    end
  end

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// tb/tb_serial_magnitude_compare.sv - scoreboard bench for serial_magnitude_compare
module tb_serial_magnitude_compare;

  localparam int W = 8;

  typedef struct {
    logic [2:0] flags;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic a_bit = 1'b0;
  logic b_bit = 1'b0;
  logic busy, done, gt, lt, eq;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   stop_req = 1'b0;

  serial_magnitude_compare #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
    .gt(gt), .lt(lt), .eq(eq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations on done, enforces flag hold and reset values.
  initial begin
    logic [2:0] held;
    bit         armed, rst_pend;
    exp_t       e;
    held = 3'b000;
    armed = 1'b0;
    rst_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (stop_req) begin
        total++;
        if (q.size() != 0) begin
          bad++;
          $display("FAIL pending_results: %0d outstanding, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      if (rst_pend) begin
        total++;
        if ({busy, done, gt, lt, eq} !== 5'b00000) begin
          bad++;
          $display("FAIL reset_state: busy/done/gt/lt/eq=%b required 00000", {busy, done, gt, lt, eq});
        end
        held = 3'b000;
        armed = 1'b1;
      end else if (armed && done === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: at cycle %0d, none required", cyc);
        end else begin
          e = q.pop_front();
          if ({gt, lt, eq} !== e.flags || cyc != e.cyc) begin
            bad++;
            $display("FAIL result: flags=%b cycle=%0d required flags=%b cycle=%0d",
                     {gt, lt, eq}, cyc, e.flags, e.cyc);
          end
          held = e.flags;
        end
      end else if (armed) begin
        total++;
        if ({gt, lt, eq} !== held) begin
          bad++;
          $display("FAIL flag_hold: flags=%b at cycle %0d required %b", {gt, lt, eq}, cyc, held);
        end
      end
      rst_pend = (reset === 1'b1);
    end
  end

  // toggle: bit_valid 1,0,1,0...; junk: start pulses while busy;
  // keep: start stays high for back-to-back; abort_at>=0: reset after that many bits.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] exp_f, input bit toggle,
                         input bit junk, input bit keep, input int abort_at);
    exp_t e;
    start = 1'b1;
    bit_valid = 1'b1;
    a_bit = ~a[W-1];
    b_bit = a[W-1];
    @(posedge clk); #1;
    if (abort_at < 0) begin
      e.flags = exp_f;
      e.cyc = cyc + (toggle ? 2 * W - 1 : W);
      q.push_back(e);
    end
    for (int i = 0; i < W; i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        bit_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      start = keep || (junk && (i == 2 || i == 5));
      bit_valid = 1'b1;
      a_bit = a[W-1-i];
      b_bit = b[W-1-i];
      @(posedge clk); #1;
      if (toggle && i < W - 1) begin
        bit_valid = 1'b0;
        a_bit = 1'($urandom);
        b_bit = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    start = keep;
    bit_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_cmp(8'hA5, 8'hA3, 3'b100, 1'b0, 1'b0, 1'b0, -1);
    repeat (20) @(posedge clk);
    #1;
    run_cmp(8'h3C, 8'h3C, 3'b001, 1'b0, 1'b0, 1'b0, -1);
    run_cmp(8'h00, 8'h80, 3'b010, 1'b0, 1'b0, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    run_cmp(8'hA5, 8'hA3, 3'b100, 1'b1, 1'b0, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    run_cmp(8'h5A, 8'h5B, 3'b010, 1'b0, 1'b1, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    run_cmp(8'hF0, 8'h0F, 3'b100, 1'b0, 1'b0, 1'b0, 4);
    repeat (3) @(posedge clk);
    #1;
    run_cmp(8'h12, 8'h12, 3'b001, 1'b0, 1'b0, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 50; n++) begin
      ra = W'($urandom);
      rb = (n % 5 == 0) ? ra : W'($urandom);
      run_cmp(ra, rb, {ra > rb, ra < rb, ra == rb}, 1'b0, 1'b0, 1'b1, -1);
    end
    start = 1'b0;
    for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    stop_req = 1'b1;
  end

endmodule
